loc_updater: RTL

Write-back stage of the graph partitioning pipeline. After `worker` raises `ready` for a batch, `loc_updater` reads the `worker` outputs back out of the next/pro SRAMs together with the batch's vertex IDs. For each vertex it does a read-modify-write of the vertex's slot in the location SRAM, so the next batch sees updated partition assignments. It is the reader/consumer end of the next/pro buffers that `worker` writes.

---
 rtl/loc_updater_if.sv | 48 ++++
 rtl/loc_updater.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/loc_updater_if.sv
// Bus bundle between loc_updater and the surrounding SRAMs / worker.
//
// Handshake: start is a one-cycle request from worker; it is honoured only
// while the updater is idle and dropped otherwise. busy is high while a batch
// is in progress; done pulses for exactly one cycle when the batch completes,
// at which point upd_cnt is final. The SRAM side has no flow control: every
// read address returns data exactly one cycle later, and loc_wen commits
// loc_wdata to loc_waddr on the same clock edge. dbg_state mirrors the
// updater FSM state for observation.
interface loc_updater_if #(
  parameter int D               = 256,
  parameter int Q               = 16,
  parameter int LOC_BW          = 5,
  parameter int LOC_ADDR_SPACE  = 4,
  parameter int NEXT_BW         = 4,
  parameter int NEXT_ADDR_SPACE = 4,
  parameter int PRO_BW          = 8,
  parameter int VID_BW          = 16
);
  logic                         start;
  logic [NEXT_ADDR_SPACE-1:0]   row_raddr;
  logic [Q*VID_BW-1:0]          vid_rdata;
  logic [Q*NEXT_BW-1:0]         next_rdata;
  logic [Q*PRO_BW-1:0]          pro_rdata;
  logic [LOC_ADDR_SPACE-1:0]    loc_raddr;
  logic [D*LOC_BW-1:0]          loc_rdata;
  logic                         loc_wen;
  logic [LOC_ADDR_SPACE-1:0]    loc_waddr;
  logic [D*LOC_BW-1:0]          loc_wdata;
  logic                         busy;
  logic                         done;
  logic [8:0]                   upd_cnt;
  logic [2:0]                   dbg_state;

  // Updater side
  modport master (
    input  start, vid_rdata, next_rdata, pro_rdata, loc_rdata,
    output row_raddr, loc_raddr, loc_wen, loc_waddr, loc_wdata,
           busy, done, upd_cnt, dbg_state
  );

  // SRAM / control side
  modport slave (
    output start, vid_rdata, next_rdata, pro_rdata, loc_rdata,
    input  row_raddr, loc_raddr, loc_wen, loc_waddr, loc_wdata,
           busy, done, upd_cnt, dbg_state
  );
endinterface

// File: rtl/loc_updater.sv
// loc_updater: write-back stage of the partitioning pipeline. Walks the
// next/pro/vid rows produced by worker and, for every non-empty lane, does a
// read-modify-write of that vertex's slot in the location SRAM, setting it to
// {1'b1, next}. Exactly one RMW is in flight at a time, so back-to-back
// vertices hitting the same loc row need no forwarding.
//
// Optional feature macro: LOC_UPD_PRO_FILTER_EN. When defined, a lane whose
// promotion score is below PRO_THRES is skipped and its loc entry kept.
module loc_updater #(
  parameter int                D               = 256,
  parameter int                Q               = 16,
  parameter int                LOC_BW          = 5,
  parameter int                LOC_ADDR_SPACE  = 4,
  parameter int                NEXT_BW         = 4,
  parameter int                NEXT_ADDR_SPACE = 4,
  parameter int                PRO_BW          = 8,
  parameter int                VID_BW          = 16,
  parameter logic [PRO_BW-1:0] PRO_THRES       = 8'd4
) (
  input logic            clk,
  input logic            rst_n,
  loc_updater_if.master  bus
);

  localparam int SLOT_BW = $clog2(D);
  localparam int LANE_BW = $clog2(Q);
  localparam int WBITS   = $clog2(D*LOC_BW);

`ifdef LOC_UPD_PRO_FILTER_EN
  localparam bit PRO_FILTER = 1'b1;
`else
  localparam bit PRO_FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_RD    = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                      state, state_next;
  logic [NEXT_ADDR_SPACE-1:0]  row_q;
  logic [LANE_BW-1:0]          lane_q;
  logic [8:0]                  upd_cnt_q;

  logic [VID_BW-1:0]           vid_q  [Q];
  logic [NEXT_BW-1:0]          next_q [Q];
  logic [PRO_BW-1:0]           pro_q  [Q];

  logic [VID_BW-1:0]           cur_vid;
  logic [NEXT_BW-1:0]          cur_next;
  logic [PRO_BW-1:0]           cur_pro;
  logic [SLOT_BW-1:0]          cur_slot;
  logic [LOC_ADDR_SPACE-1:0]   cur_row;
  logic [WBITS-1:0]            wbase;
  logic                        lane_skip;
  logic                        last_lane;
  logic                        last_row;
  logic                        lane_adv;

  // Current-lane decode: which vertex we are on, where it lives, and whether it is skipped
  always_comb begin
    cur_vid   = vid_q[lane_q];
    cur_next  = next_q[lane_q];
    cur_pro   = pro_q[lane_q];
    cur_slot  = cur_vid[SLOT_BW-1:0];
    cur_row   = cur_vid[SLOT_BW +: LOC_ADDR_SPACE];
    // Slot j sits MSB-first, so its LSB is at (D-1-j)*LOC_BW
    wbase     = WBITS'((D - 1 - int'(cur_slot)) * LOC_BW);
    lane_skip = (cur_vid == {VID_BW{1'b1}}) || (PRO_FILTER && (cur_pro < PRO_THRES));
    last_lane = (lane_q == LANE_BW'(Q - 1));
    last_row  = (row_q == {NEXT_ADDR_SPACE{1'b1}});
    lane_adv  = ((state == S_RD) && lane_skip) || (state == S_WR);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_FETCH;
      S_FETCH: state_next = S_LATCH;
      S_LATCH: state_next = S_RD;
      S_RD: begin
        if (!lane_skip)     state_next = S_WR;
        else if (last_lane) state_next = last_row ? S_DONE : S_FETCH;
        else                state_next = S_RD;
      end
      S_WR: begin
        if (last_lane) state_next = last_row ? S_DONE : S_FETCH;
        else           state_next = S_RD;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: SRAM addresses, loc write strobe/row, busy and done
  always_comb begin
    bus.row_raddr = '0;
    bus.loc_raddr = '0;
    bus.loc_wen   = 1'b0;
    bus.loc_waddr = '0;
    bus.loc_wdata = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      S_FETCH: begin
        bus.busy      = 1'b1;
        bus.row_raddr = row_q;
      end
      S_LATCH: bus.busy = 1'b1;
      S_RD: begin
        bus.busy = 1'b1;
        if (!lane_skip) bus.loc_raddr = cur_row;
      end
      S_WR: begin
        bus.busy      = 1'b1;
        bus.loc_wen   = 1'b1;
        bus.loc_waddr = cur_row;
        bus.loc_wdata = bus.loc_rdata;
        bus.loc_wdata[wbase +: LOC_BW] = {1'b1, cur_next};
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Row/lane walk and update counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q     <= '0;
      lane_q    <= '0;
      upd_cnt_q <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        row_q     <= '0;
        upd_cnt_q <= '0;
      end
      if (state == S_LATCH) lane_q <= '0;
      if (state == S_WR) upd_cnt_q <= upd_cnt_q + 9'd1;
      if (lane_adv) begin
        if (last_lane) begin
          lane_q <= '0;
          if (!last_row) row_q <= row_q + NEXT_ADDR_SPACE'(1);
        end else begin
          lane_q <= lane_q + LANE_BW'(1);
        end
      end
    end
  end

  // Capture the vid/next/pro rows one cycle after FETCH drove the address
  always_ff @(posedge clk) begin
    if (state == S_LATCH) begin
      for (int i = 0; i < Q; i++) begin
        vid_q[i]  <= bus.vid_rdata[(Q-i)*VID_BW-1 -: VID_BW];
        next_q[i] <= bus.next_rdata[(Q-i)*NEXT_BW-1 -: NEXT_BW];
        pro_q[i]  <= bus.pro_rdata[(Q-i)*PRO_BW-1 -: PRO_BW];
      end
    end
  end

  assign bus.upd_cnt   = upd_cnt_q;
  assign bus.dbg_state = state;

endmodule
